// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encodings, the debounce
// default and the Moore output decode used by the FSM.
package stopwatch_defs;

  localparam logic [15:0] DEB_CYCLES_DEFAULT = 16'd50000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } sw_state_e;

  typedef struct packed {
    logic enable;
    logic ncount_reset;
    logic freeze;
  } sw_out_t;

  function automatic sw_out_t decode_outputs(input sw_state_e st);
    sw_out_t o;
    case (st)
      IDLE:    o = '{enable: 1'b0, ncount_reset: 1'b0, freeze: 1'b0};
      RUN:     o = '{enable: 1'b1, ncount_reset: 1'b1, freeze: 1'b0};
      LAP:     o = '{enable: 1'b1, ncount_reset: 1'b1, freeze: 1'b1};
      STOP:    o = '{enable: 1'b0, ncount_reset: 1'b1, freeze: 1'b0};
      default: o = '{enable: 1'b0, ncount_reset: 1'b0, freeze: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// Raw button -> 2-flop synchronizer -> optional debouncer -> 1-cycle rising-edge pulse.
// Debounce counter is built only when STOPWATCH_DEBOUNCE_EN is defined.
module btn_conditioner
  import stopwatch_defs::*;
#(
  parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic clean_s;
  logic prev_q;
  logic pulse_q;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  logic        level_q;
  logic        level_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Level flips on the DEB_CYCLES-th consecutive cycle of disagreement
  always_comb begin
    level_d = level_q;
    cnt_d   = 16'd0;
    if (sync2_q != level_q) begin
      if (({1'b0, cnt_q} + 17'd1) >= {1'b0, DEB_CYCLES}) begin
        level_d = sync2_q;
        cnt_d   = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_s = level_q;
`else
  // Without debouncing the parameter has no effect; fold it into a sink net.
  logic unused_deb_s;
  assign unused_deb_s = ^DEB_CYCLES;
  assign clean_s      = sync2_q;
`endif

  // Registered rising-edge detector: one pulse per press, none on release
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= clean_s;
      pulse_q <= clean_s & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller (IDLE/RUN/LAP/STOP) driven by three conditioned buttons.
// Define STOPWATCH_DEBOUNCE_EN to insert the DEB_CYCLES debouncer in each button path.
module stopwatch_ctrl
  import stopwatch_defs::*;
#(
  parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       NEclk,
  input  logic       Reset,
  input  logic       Btn_start_stop,
  input  logic       Btn_lap,
  input  logic       Btn_clear,
  output logic       Enable,
  output logic       Ncount_reset,
  output logic       Freeze,
  output logic [1:0] State
);

  logic      ss_p_s;
  logic      lap_p_s;
  logic      clr_p_s;
  sw_state_e state_q;
  sw_state_e state_d;
  sw_out_t   out_q;
  sw_out_t   out_d;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_ss (
    .clk_i   (NEclk),
    .rst_i   (Reset),
    .btn_i   (Btn_start_stop),
    .pulse_o (ss_p_s)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_lap (
    .clk_i   (NEclk),
    .rst_i   (Reset),
    .btn_i   (Btn_lap),
    .pulse_o (lap_p_s)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_clr (
    .clk_i   (NEclk),
    .rst_i   (Reset),
    .btn_i   (Btn_clear),
    .pulse_o (clr_p_s)
  );

  always_ff @(negedge NEclk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only pulses meaningful in the current state compete; clear > start_stop > lap
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ss_p_s) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (ss_p_s)       state_d = STOP;
        else if (lap_p_s) state_d = LAP;
        else              state_d = RUN;
      end
      LAP: begin
        if (ss_p_s)       state_d = STOP;
        else if (lap_p_s) state_d = RUN;
        else              state_d = LAP;
      end
      STOP: begin
        if (clr_p_s)     state_d = IDLE;
        else if (ss_p_s) state_d = RUN;
        else             state_d = STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d = decode_outputs(state_d);
  end

  // Outputs registered alongside the state so they always match its decode
  always_ff @(negedge NEclk) begin
    if (Reset) begin
      out_q <= decode_outputs(IDLE);
    end else begin
      out_q <= out_d;
    end
  end

  assign State        = state_q;
  assign Enable       = out_q.enable;
  assign Ncount_reset = out_q.ncount_reset;
  assign Freeze       = out_q.freeze;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random button
// traffic, compared each cycle against a sample-history reference model.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT       = DEB + 4;
  localparam int RST_DLY   = 5;
  localparam int BOUNCE_EX = 3;
`else
  localparam int LAT       = 4;
  localparam int RST_DLY   = 2;
  localparam int BOUNCE_EX = 1;
`endif
  localparam int MAXE   = 40000;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_LAP  = 2;
  localparam int M_STOP = 3;

  logic       NEclk = 1'b0;
  logic       Reset = 1'b1;
  logic       Btn_start_stop = 1'b0;
  logic       Btn_lap = 1'b0;
  logic       Btn_clear = 1'b0;
  logic       Enable;
  logic       Ncount_reset;
  logic       Freeze;
  logic [1:0] State;

  stopwatch_ctrl #(.DEB_CYCLES(16'(DEB))) dut (
    .NEclk          (NEclk),
    .Reset          (Reset),
    .Btn_start_stop (Btn_start_stop),
    .Btn_lap        (Btn_lap),
    .Btn_clear      (Btn_clear),
    .Enable         (Enable),
    .Ncount_reset   (Ncount_reset),
    .Freeze         (Freeze),
    .State          (State)
  );

  always #5 NEclk = ~NEclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-edge histories of raw samples, accepted levels and pulses
  bit rst_h [MAXE];
  bit raw_h [3][MAXE];
  bit s_h   [3][MAXE];
  bit lv_h  [3][MAXE];
  bit p_h   [3][MAXE];
  int k        = 2;
  int mst      = M_IDLE;
  bit model_ok = 1'b0;

  function automatic int fsm_next(input int st, input bit ss, input bit lp, input bit cl);
    case (st)
      M_IDLE:  return ss ? M_RUN : M_IDLE;
      M_RUN:   return ss ? M_STOP : (lp ? M_LAP : M_RUN);
      M_LAP:   return ss ? M_STOP : (lp ? M_RUN : M_LAP);
      M_STOP:  return cl ? M_IDLE : (ss ? M_RUN : M_STOP);
      default: return M_IDLE;
    endcase
  endfunction

  // {Enable, Ncount_reset, Freeze}
  function automatic logic [2:0] exp_out(input int st);
    case (st)
      M_RUN:   return 3'b110;
      M_LAP:   return 3'b111;
      M_STOP:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  always @(negedge NEclk) begin : model
    bit cur[3];
    bit lv;
    bit all_diff;
    cur[0] = Btn_start_stop;
    cur[1] = Btn_lap;
    cur[2] = Btn_clear;
    if (k >= MAXE - 2) begin
      $display("FAIL model_depth: got %0d expected below %0d", k, MAXE - 2);
      $fatal(1);
    end
    k = k + 1;
    rst_h[k] = Reset;
    for (int b = 0; b < 3; b++) begin
      raw_h[b][k] = cur[b];
      s_h[b][k]   = (rst_h[k-1] || rst_h[k-2]) ? 1'b0 : raw_h[b][k-2];
`ifdef STOPWATCH_DEBOUNCE_EN
      if (rst_h[k]) begin
        lv = 1'b0;
      end else begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (s_h[b][k-j] == lv_h[b][k-1]) all_diff = 1'b0;
        lv = all_diff ? ~lv_h[b][k-1] : lv_h[b][k-1];
      end
`else
      lv = (rst_h[k] || rst_h[k-1]) ? 1'b0 : raw_h[b][k-1];
`endif
      lv_h[b][k] = lv;
      p_h[b][k]  = rst_h[k] ? 1'b0 : (lv_h[b][k-1] & ~lv_h[b][k-2]);
    end
    if (Reset) begin
      mst      = M_IDLE;
      model_ok = 1'b1;
    end else begin
      mst = fsm_next(mst, p_h[0][k-1], p_h[1][k-1], p_h[2][k-1]);
    end
  end

  always @(posedge NEclk) begin
    if (model_ok) begin
      chk("state", 8'(State), 8'(mst));
      chk("outs", {5'd0, Enable, Ncount_reset, Freeze}, {5'd0, exp_out(mst)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge NEclk);
  endtask

  task automatic press(input bit ss, input bit lp, input bit cl, input int hold, input int gap);
    Btn_start_stop = ss;
    Btn_lap        = lp;
    Btn_clear      = cl;
    cyc(hold);
    Btn_start_stop = 1'b0;
    Btn_lap        = 1'b0;
    Btn_clear      = 1'b0;
    cyc(gap);
  endtask

  task automatic measure_latency(input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= 50 && lat == 0; i++) begin
      @(negedge NEclk);
      #1;
      if (State == 2'b01) lat = i;
    end
    if (lat == 0) lat = 255;
    chk(tag, 8'(lat), 8'(LAT));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    cyc(3);
    Reset = 1'b0;
    cyc(1);
    chk("rst_state", 8'(State), 8'd0);
    chk("rst_outs", {5'd0, Enable, Ncount_reset, Freeze}, 8'd0);

    // Start press held 10 cycles: exact latency, single transition
    cyc(2);
    Btn_start_stop = 1'b1;
    measure_latency("start_latency");
    cyc(2);
    Btn_start_stop = 1'b0;
    cyc(14);
    chk("run_state", 8'(State), 8'd1);
    chk("run_enable", 8'(Enable), 8'd1);

    // Bounce then clean press
    for (int i = 0; i < 10; i++) begin
      Btn_start_stop = ~Btn_start_stop;
      cyc(2);
    end
    Btn_start_stop = 1'b0;
    cyc(14);
    press(1'b1, 1'b0, 1'b0, 6, 14);
    chk("bounce_then_press", 8'(State), 8'(BOUNCE_EX));

    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    cyc(2);
    press(1'b1, 1'b0, 1'b0, 6, 14);
    press(1'b0, 1'b1, 1'b0, 6, 14);
    chk("lap_state", 8'(State), 8'd2);
    chk("lap_freeze", 8'(Freeze), 8'd1);
    chk("lap_enable", 8'(Enable), 8'd1);
    press(1'b0, 1'b1, 1'b0, 6, 14);
    chk("lap_back_run", 8'(State), 8'd1);
    chk("run_freeze", 8'(Freeze), 8'd0);
    press(1'b0, 1'b1, 1'b0, 6, 14);
    press(1'b0, 1'b0, 1'b1, 6, 14);
    chk("clear_in_lap", 8'(State), 8'd2);
    press(1'b1, 1'b0, 1'b0, 6, 14);
    chk("stop_state", 8'(State), 8'd3);
    press(1'b1, 1'b0, 1'b1, 6, 14);
    chk("clear_beats_ss", 8'(State), 8'd0);
    chk("idle_ncr", 8'(Ncount_reset), 8'd0);

    // Reset in LAP while a start_stop press is being conditioned
    press(1'b1, 1'b0, 1'b0, 6, 14);
    press(1'b0, 1'b1, 1'b0, 6, 14);
    chk("lap_again", 8'(State), 8'd2);
    Btn_start_stop = 1'b1;
    cyc(RST_DLY);
    Reset = 1'b1;
    Btn_start_stop = 1'b0;
    cyc(1);
    Reset = 1'b0;
    chk("midrst_state", 8'(State), 8'd0);
    chk("midrst_outs", {5'd0, Enable, Ncount_reset, Freeze}, 8'd0);
    cyc(20);
    chk("no_stale_pulse", 8'(State), 8'd0);

    // Button held across reset release counts as one press
    Btn_start_stop = 1'b1;
    Reset = 1'b1;
    cyc(3);
    Reset = 1'b0;
    measure_latency("held_reset_latency");
    cyc(6);
    Btn_start_stop = 1'b0;
    cyc(14);

    // Random traffic, checked every cycle against the model
    for (int it = 0; it < 250; it++) begin
      int hold;
      int gap;
      logic [2:0] mask;
      hold = int'($urandom_range(1, 10));
      gap  = int'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) begin
        Reset = 1'b1;
        cyc(int'($urandom_range(1, 2)));
        Reset = 1'b0;
      end else begin
        if ($urandom_range(0, 5) == 0) mask = 3'($urandom_range(1, 7));
        else mask = 3'b001 << $urandom_range(0, 2);
        if ($urandom_range(0, 3) == 0) begin
          for (int j = 0; j < hold; j++) begin
            Btn_start_stop = mask[0] & 1'($urandom);
            Btn_lap        = mask[1] & 1'($urandom);
            Btn_clear      = mask[2] & 1'($urandom);
            cyc(1);
          end
          press(1'b0, 1'b0, 1'b0, 1, gap);
        end else begin
          press(mask[0], mask[1], mask[2], hold, gap);
        end
      end
    end
    cyc(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: DEB_CYCLES, default 50000, consecutive stable cycles needed to accept a button level; 16 bits wide.
REQ-002 Port: NEclk  in  1  sole clock; all state SHALL update on its falling edge.
REQ-003 Port: Reset  in  1  synchronous, active-high reset.
REQ-004 Port: Btn_start_stop  in  1  raw asynchronous button, active-high.
REQ-005 Port: Btn_lap  in  1  raw asynchronous button, active-high.
REQ-006 Port: Btn_clear  in  1  raw asynchronous button, active-high.
REQ-007 Port: Enable  out  1  counting enable to the downstream stopwatch counter.
REQ-008 Port: Ncount_reset  out  1  active-low clear to the downstream counter.
REQ-009 Port: Freeze  out  1  display-hold request: the downstream BCD latch holds the lap time.
REQ-010 Port: State  out  2  current FSM state encoding.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer, then a rising-edge detector that produces a 1-cycle registered pulse.
REQ-012 Debouncer: the accepted level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any cycle of agreement SHALL clear the counter to 0.
REQ-013 Latency from a raw step to a State change SHALL be DEB_CYCLES+4 edges (edges 1-2 synchronize, DEB_CYCLES debounce, 1 edge-detect, 1 state update).
REQ-014 FSM states SHALL be: IDLE=00, RUN=01, LAP=10, STOP=11.
REQ-015 Outputs SHALL be Moore-decoded from the state register:
- IDLE: Enable=0, Ncount_reset=0, Freeze=0
- RUN: Enable=1, Ncount_reset=1, Freeze=0
- LAP: Enable=1, Ncount_reset=1, Freeze=1
- STOP: Enable=0, Ncount_reset=1, Freeze=0
REQ-016 Transitions:
- IDLE: start_stop -> RUN.
- RUN: start_stop -> STOP; lap -> LAP.
- LAP: lap -> RUN; start_stop -> STOP.
- STOP: start_stop -> RUN (resume, count preserved); clear -> IDLE.
REQ-017 Pulses not listed in REQ-016 SHALL be ignored; specifically, clear is ignored in RUN/LAP and lap is ignored in IDLE/STOP.
REQ-018 Pulses arriving in the same cycle SHALL be prioritized clear > start_stop > lap; at most one transition per cycle, and lower-priority pulses in that cycle are discarded.
REQ-019 A held button SHALL yield exactly one pulse per press; the release SHALL produce no pulse.

Reset
REQ-020 While Reset=1 on a falling edge: State=IDLE; synchronizers, accepted levels, debounce counters and pulse registers all SHALL clear to 0; outputs SHALL be Enable=0, Ncount_reset=0, Freeze=0.
REQ-021 Reset asserted mid-operation (any state, mid-debounce) SHALL take effect on the next falling edge and SHALL override all pulses in that cycle.
REQ-022 A button held high across reset release SHALL register as one press after the REQ-013 latency.

Configuration
REQ-023 Macro STOPWATCH_DEBOUNCE_EN defined: debounce counters present per REQ-012.
REQ-024 Macro undefined: the synchronized level SHALL feed the edge detector directly, no counters SHALL exist, DEB_CYCLES SHALL be ignored, and latency SHALL be 4 edges.

Structure
REQ-025 Shared package stopwatch_defs SHALL hold the state encodings (IDLE/RUN/LAP/STOP) and the DEB_CYCLES default.
REQ-026 Sub-module btn_conditioner (synchronizer + debouncer + edge detect, DEB_CYCLES parameter) SHALL be instantiated three times.

Verification (DEB_CYCLES=4, macro defined unless noted)
REQ-027 Reset, then a Btn_start_stop high for 10 cycles -> State=01 and Enable=1 exactly 8 edges after the step; exactly one transition.
REQ-028 In RUN, Btn_start_stop toggling every 2 cycles for 20 cycles, then low -> no State change from the bounce; a clean 6-cycle press -> STOP.
REQ-029 RUN, lap press -> LAP (Freeze=1, Enable=1); second lap press -> RUN (Freeze=0); clear press in LAP -> no change.
REQ-030 STOP, with clear and start_stop pressed on the same edge -> IDLE (Ncount_reset=0), not RUN.
REQ-031 Reset=1 for 1 cycle while in LAP mid-debounce -> next edge: State=00, Enable=0, Freeze=0, Ncount_reset=0; no stale pulse afterwards.
REQ-032 Macro undefined: a 1-cycle raw start_stop pulse in IDLE -> RUN 4 edges later.
